signext_pipe: RTL and testbench

//  Registered, parametrised immediate generator for the LEGv8 decode stage; successor to combinational signext.

---
 rtl/signext_pipe.sv | 145 ++++++++++++++
 tb/tb_signext_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/signext_pipe.sv
`timescale 1ns/1ps
// LEGv8 immediate generator (D/CB/B/I/IW) with a valid/ready 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid; throughput 1/cycle when out_ready=1.
// Backpressure: in_ready drops only when both M and S hold entries; outputs hold while stalled.
module signext_pipe #(
    parameter int N     = 64,
    parameter int EN_IW = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] imm,
    output logic [2:0]   fmt,
    output logic         err
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_D    = 3'd1;
    localparam logic [2:0] FMT_CB   = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_I    = 3'd4;
    localparam logic [2:0] FMT_IW   = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic         accept, drain;
    logic         load_m_dec, load_m_skid, load_s;

    logic [N-1:0] dec_imm;
    logic [2:0]   dec_fmt;
    logic         dec_err;
    logic [5:0]   iw_shamt;

    logic [N-1:0] m_imm, s_imm;
    logic [2:0]   m_fmt, s_fmt;
    logic         m_err, s_err;

    assign iw_shamt = {instr[22:21], 4'b0000};

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_err = 1'b0;
        if (instr[31:21] == 11'h7C2 || instr[31:21] == 11'h7C0) begin
            dec_imm = {{(N-9){instr[20]}}, instr[20:12]};
            dec_fmt = FMT_D;
        end else if (instr[31:24] == 8'hB4 || instr[31:24] == 8'hB5) begin
            dec_imm = {{(N-19){instr[23]}}, instr[23:5]};
            dec_fmt = FMT_CB;
        end else if (instr[31:26] == 6'b000101) begin
            dec_imm = {{(N-26){instr[25]}}, instr[25:0]};
            dec_fmt = FMT_B;
        end else if (instr[31:22] == 10'h244 || instr[31:22] == 10'h344) begin
            dec_imm = {{(N-12){1'b0}}, instr[21:10]};
            dec_fmt = FMT_I;
        end else if (EN_IW != 0 && instr[31:23] == 9'h1A5) begin
            // Shifting at width N drops halfword placements that land above the result.
            dec_imm = N'(instr[20:5]) << iw_shamt;
            dec_fmt = FMT_IW;
        end else begin
            dec_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !drain) begin
                    state_nxt = ST_FULL;
                end else if (!accept && drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL:  if (drain) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_comb begin
        out_valid   = (state_q != ST_EMPTY);
        in_ready    = (state_q != ST_FULL);
        accept      = in_valid && in_ready;
        drain       = out_valid && out_ready;
        // A flush discards the incoming word; the outgoing handshake still completes.
        load_m_dec  = accept && !flush &&
                      (state_q == ST_EMPTY || (state_q == ST_ONE && drain));
        load_s      = accept && !flush && state_q == ST_ONE && !drain;
        load_m_skid = drain && !flush && state_q == ST_FULL;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_imm <= '0;
            m_fmt <= FMT_NONE;
            m_err <= 1'b0;
            s_imm <= '0;
            s_fmt <= FMT_NONE;
            s_err <= 1'b0;
        end else begin
            if (load_m_dec) begin
                m_imm <= dec_imm;
                m_fmt <= dec_fmt;
                m_err <= dec_err;
            end else if (load_m_skid) begin
                m_imm <= s_imm;
                m_fmt <= s_fmt;
                m_err <= s_err;
            end
            if (load_s) begin
                s_imm <= dec_imm;
                s_fmt <= dec_fmt;
                s_err <= dec_err;
            end
        end
    end

    assign imm = m_imm;
    assign fmt = m_fmt;
    assign err = m_err;

endmodule

// File: tb/tb_signext_pipe.sv
`timescale 1ns/1ps
// Directed bench for signext_pipe: a 64-bit build and a 32-bit build share one stimulus stream.
module tb_signext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;

    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] LDUR_M16  = 32'hF85F_0000;
    localparam logic [31:0] CBZ_P4    = 32'hB400_0080;
    localparam logic [31:0] CBNZ_M1   = 32'hB5FF_FFE0;
    localparam logic [31:0] B_M1      = 32'h17FF_FFFF;
    localparam logic [31:0] ADDI_FFF  = 32'h913F_FC00;
    localparam logic [31:0] MOVZ_HW2  = 32'hD2D5_79A0;
    localparam logic [31:0] MOVZ_HW3  = 32'hD2E2_4680;

    signext_pipe #(.N(64), .EN_IW(1)) u_dut64 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .instr     (instr),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .imm       (imm64),
        .fmt       (fmt64),
        .err       (err64)
    );

    signext_pipe #(.N(32), .EN_IW(1)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .instr     (instr),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .imm       (imm32),
        .fmt       (fmt32),
        .err       (err32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [63:0] exp_imm,
                           input logic [2:0] exp_fmt, input logic exp_err);
        chk({tag, ".vld"}, {63'd0, out_valid64}, {63'd0, vld});
        chk({tag, ".imm"}, imm64, exp_imm);
        chk({tag, ".fmt"}, {61'd0, fmt64}, {61'd0, exp_fmt});
        chk({tag, ".err"}, {63'd0, err64}, {63'd0, exp_err});
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = 32'h0;

        // reset held for two cycles
        tick();
        tick();
        chk_out("rst", 1'b0, 64'h0, 3'd0, 1'b0);
        chk("rst.rdy64", {63'd0, in_ready64}, 64'd1);
        chk("rst.rdy32", {63'd0, in_ready32}, 64'd1);
        chk("rst.vld32", {63'd0, out_valid32}, 64'd0);
        chk("rst.imm32", {32'd0, imm32}, 64'h0);
        reset = 1'b1;
        tick();

        // formats, one per cycle, out_ready=1
        in_valid = 1'b1;
        instr = LDUR_M16;
        tick();
        chk_out("ldur", 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 3'd1, 1'b0);
        chk("ldur.imm32", {32'd0, imm32}, {32'd0, 32'hFFFF_FFF0});
        instr = CBZ_P4;
        tick();
        chk_out("cbz", 1'b1, 64'h4, 3'd2, 1'b0);
        instr = B_M1;
        tick();
        chk_out("b", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 1'b0);
        instr = MOVZ_HW2;
        tick();
        chk_out("movz2", 1'b1, 64'h0000_ABCD_0000_0000, 3'd5, 1'b0);
        chk("movz2.imm32", {32'd0, imm32}, 64'h0);
        instr = CBNZ_M1;
        tick();
        chk_out("cbnz", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b0);
        instr = ADDI_FFF;
        tick();
        chk_out("addi", 1'b1, 64'h0000_0000_0000_0FFF, 3'd4, 1'b0);
        instr = 32'h0000_0000;
        tick();
        chk_out("unk", 1'b1, 64'h0, 3'd0, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("idle.vld", {63'd0, out_valid64}, 64'd0);

        // backpressure: three offered, two accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = LDUR_M16;
        tick();
        chk_out("bp1", 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 3'd1, 1'b0);
        chk("bp1.rdy", {63'd0, in_ready64}, 64'd1);
        instr = CBZ_P4;
        tick();
        chk("bp2.rdy", {63'd0, in_ready64}, 64'd0);
        chk_out("bp2", 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 3'd1, 1'b0);
        instr = B_M1;
        tick();
        chk("bp3.rdy", {63'd0, in_ready64}, 64'd0);
        chk_out("bp3", 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 3'd1, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_out("bp.drain1", 1'b1, 64'h4, 3'd2, 1'b0);
        chk("bp.drain1.rdy", {63'd0, in_ready64}, 64'd1);
        tick();
        chk("bp.drain2.vld", {63'd0, out_valid64}, 64'd0);

        // flush while FULL with a word offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = LDUR_M16;
        tick();
        instr = CBZ_P4;
        tick();
        chk("fl.full.rdy", {63'd0, in_ready64}, 64'd0);
        flush = 1'b1;
        instr = B_M1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl.vld", {63'd0, out_valid64}, 64'd0);
        chk("fl.rdy", {63'd0, in_ready64}, 64'd1);
        tick();
        chk("fl.after.vld", {63'd0, out_valid64}, 64'd0);

        // flush in ONE discards a same-cycle accept
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = LDUR_M16;
        tick();
        chk("fl1.pre.vld", {63'd0, out_valid64}, 64'd1);
        flush = 1'b1;
        instr = CBZ_P4;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl1.vld", {63'd0, out_valid64}, 64'd0);

        // 32-bit truncation of MOVZ hw=3
        in_valid = 1'b1;
        instr    = MOVZ_HW3;
        tick();
        chk("movz3.imm32", {32'd0, imm32}, 64'h0);
        chk("movz3.fmt32", {61'd0, fmt32}, 64'd5);
        chk("movz3.imm64", imm64, 64'h1234_0000_0000_0000);
        instr = LDUR_M16;
        tick();
        chk("ldur32.imm", {32'd0, imm32}, {32'd0, 32'hFFFF_FFF0});
        chk("ldur32.fmt", {61'd0, fmt32}, 64'd1);

        // reset asserted while FULL
        out_ready = 1'b0;
        instr     = CBZ_P4;
        tick();
        chk("rst2.pre.rdy", {63'd0, in_ready64}, 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk_out("rst2", 1'b0, 64'h0, 3'd0, 1'b0);
        chk("rst2.rdy", {63'd0, in_ready64}, 64'd1);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
